// File: rtl/pe_pkg.sv
// Shared types for the PE lane selector family.
// Provides the selection-mode enum, the sequencer state enum and a helper
// that folds the reserved mode encoding onto static selection.
package pe_pkg;

  typedef enum logic [1:0] {
    PE_SEL_STATIC  = 2'b00,
    PE_SEL_SCAN_UP = 2'b01,
    PE_SEL_SCAN_DN = 2'b10,
    PE_SEL_RSVD    = 2'b11
  } pe_sel_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } pe_mux_seq_state_e;

  // The reserved encoding behaves exactly like static selection, so it is
  // normalised once at load time and the datapath only ever sees 3 modes.
  function automatic pe_sel_mode_e pe_norm_mode(input logic [1:0] raw);
    pe_sel_mode_e m;
    m = pe_sel_mode_e'(raw);
    if (m == PE_SEL_RSVD) m = PE_SEL_STATIC;
    return m;
  endfunction

endpackage

// File: rtl/pe_mux_seq_if.sv
// Handshake bundle for pe_mux_seq: vector input side, config, beat output side.
// slave  : the sequencer (consumes vectors/config, produces beats).
// master : the producer/consumer pair driving it (testbench or PE row glue).
interface pe_mux_seq_if #(
  parameter int WIDTH     = 8,
  parameter int SEL_WIDTH = 3
);
  localparam int NUM_IN = 1 << SEL_WIDTH;

  logic [WIDTH-1:0]     in_data [NUM_IN];
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           cfg_mode;
  logic [SEL_WIDTH-1:0] cfg_sel;
  logic [SEL_WIDTH-1:0] cfg_scan_len;
  logic [WIDTH-1:0]     out_data;
  logic [SEL_WIDTH-1:0] out_sel;
  logic                 out_last;
  logic                 out_valid;
  logic                 out_ready;

  modport slave (
    input  in_data, in_valid, cfg_mode, cfg_sel, cfg_scan_len, out_ready,
    output in_ready, out_data, out_sel, out_last, out_valid
  );

  modport master (
    output in_data, in_valid, cfg_mode, cfg_sel, cfg_scan_len, out_ready,
    input  in_ready, out_data, out_sel, out_last, out_valid
  );

endinterface

// File: rtl/pe_mux.sv
// Combinational PE lane selector: out_data = in_data[sel].
// Ports: in_data (NUM_IN lanes), sel (lane index), out_data (chosen lane).
// Zero latency, no flow control.
module pe_mux #(
  parameter int WIDTH     = 8,
  parameter int SEL_WIDTH = 3
) (
  input  logic [WIDTH-1:0]     in_data [1 << SEL_WIDTH],
  input  logic [SEL_WIDTH-1:0] sel,
  output logic [WIDTH-1:0]     out_data
);

  assign out_data = in_data[sel];

endmodule

// File: rtl/pe_mux_seq.sv
// Sequenced lane emitter: registers a NUM_IN-lane vector, then emits one lane
// per beat (static lane, or scan up/down over lanes 0..scan_len) with index+last.
// Ports: clk, rst_n (sync, active-low), bus (pe_mux_seq_if.slave). First beat
// one cycle after load; out_ready=0 freezes the beat; next vector accepted in
// the last-beat cycle with no bubble.
module pe_mux_seq
  import pe_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SEL_WIDTH = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  pe_mux_seq_if.slave    bus
);

  localparam int NUM_IN = 1 << SEL_WIDTH;

  pe_mux_seq_state_e    state_q, state_d;
  logic [WIDTH-1:0]     hold_q [NUM_IN];
  logic [WIDTH-1:0]     hold_d [NUM_IN];
  logic [SEL_WIDTH-1:0] cnt_q, cnt_d;
  pe_sel_mode_e         mode_q, mode_d;
  logic [SEL_WIDTH-1:0] scan_len_q, scan_len_d;

  logic                 out_vld;
  logic                 last_beat;
  logic                 beat_acc;
  logic                 load;
  logic                 in_rdy;
  logic [WIDTH-1:0]     mux_dat;
  pe_sel_mode_e         load_mode;

  assign out_vld = (state_q == EMIT);

  // Last-beat flag comes purely from registered state.
  always_comb begin
    last_beat = 1'b1;
    case (mode_q)
      PE_SEL_SCAN_UP: last_beat = (cnt_q == scan_len_q);
      PE_SEL_SCAN_DN: last_beat = (cnt_q == '0);
      default:        last_beat = 1'b1;
    endcase
  end

  assign beat_acc  = out_vld && bus.out_ready;
  // A new vector may enter while the final beat of the current one drains.
  assign in_rdy    = rst_n && (!out_vld || (beat_acc && last_beat));
  assign load      = bus.in_valid && in_rdy;
  assign load_mode = pe_norm_mode(bus.cfg_mode);

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    scan_len_d = scan_len_q;
    if (load) begin
      hold_d     = bus.in_data;
      mode_d     = load_mode;
      scan_len_d = bus.cfg_scan_len;
      state_d    = EMIT;
      case (load_mode)
        PE_SEL_SCAN_UP: cnt_d = '0;
        PE_SEL_SCAN_DN: cnt_d = bus.cfg_scan_len;
        default:        cnt_d = bus.cfg_sel;
      endcase
    end else if (beat_acc) begin
      if (last_beat) begin
        state_d = IDLE;
      end else if (mode_q == PE_SEL_SCAN_UP) begin
        cnt_d = cnt_q + SEL_WIDTH'(1);
      end else if (mode_q == PE_SEL_SCAN_DN) begin
        cnt_d = cnt_q - SEL_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mode_q     <= PE_SEL_STATIC;
      scan_len_q <= '0;
      for (int i = 0; i < NUM_IN; i++) hold_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      scan_len_q <= scan_len_d;
      hold_q     <= hold_d;
    end
  end

  pe_mux #(
    .WIDTH     (WIDTH),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_pe_mux (
    .in_data  (hold_q),
    .sel      (cnt_q),
    .out_data (mux_dat)
  );

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_data  = out_vld ? mux_dat : '0;
  assign bus.out_sel   = out_vld ? cnt_q : '0;
  assign bus.out_last  = out_vld && last_beat;

endmodule

// File: tb/tb_pe_mux_seq.sv
module tb_pe_mux_seq;

  localparam int WIDTH     = 8;
  localparam int SEL_WIDTH = 3;
  localparam int NUM_IN    = 1 << SEL_WIDTH;
  localparam int CYC_LIMIT = 20000;

  typedef struct {
    logic [WIDTH-1:0]     d;
    logic [SEL_WIDTH-1:0] s;
    logic                 l;
  } beat_t;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;
  int   cyc;
  beat_t exp_q[$];

  pe_mux_seq_if #(.WIDTH(WIDTH), .SEL_WIDTH(SEL_WIDTH)) bus ();

  pe_mux_seq #(.WIDTH(WIDTH), .SEL_WIDTH(SEL_WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic set_vec(input logic [WIDTH-1:0] base);
    for (int i = 0; i < NUM_IN; i++) bus.in_data[i] = base + WIDTH'(i);
  endtask

  // Reference: a loaded vector becomes the list of beats it must produce.
  task automatic model_load();
    beat_t b;
    int    len;
    len = int'(bus.cfg_scan_len);
    case (bus.cfg_mode)
      2'b01: for (int i = 0; i <= len; i++) begin
        b.d = bus.in_data[i]; b.s = SEL_WIDTH'(i); b.l = (i == len);
        exp_q.push_back(b);
      end
      2'b10: for (int i = len; i >= 0; i--) begin
        b.d = bus.in_data[i]; b.s = SEL_WIDTH'(i); b.l = (i == 0);
        exp_q.push_back(b);
      end
      default: begin
        b.d = bus.in_data[bus.cfg_sel]; b.s = bus.cfg_sel; b.l = 1'b1;
        exp_q.push_back(b);
      end
    endcase
  endtask

  // One clock: check outputs mid-cycle against the model, advance model, clock.
  task automatic step();
    beat_t b;
    bit    ev, el, eir;
    @(negedge clk);
    ev  = (exp_q.size() > 0);
    el  = ev && exp_q[0].l;
    eir = rst_n && (!ev || (bus.out_ready && el));
    chk("out_valid", bus.out_valid, ev);
    chk("in_ready", bus.in_ready, eir);
    if (ev) begin
      chk("out_data", bus.out_data, exp_q[0].d);
      chk("out_sel", bus.out_sel, exp_q[0].s);
      chk("out_last", bus.out_last, exp_q[0].l);
    end else begin
      chk("idle_data", bus.out_data, 0);
      chk("idle_sel", bus.out_sel, 0);
      chk("idle_last", bus.out_last, 0);
    end
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (ev && bus.out_ready) b = exp_q.pop_front();
      if (bus.in_valid && eir) model_load();
    end
    @(posedge clk);
    #1;
    cyc++;
    if (cyc > CYC_LIMIT) begin
      $display("FAIL timeout observed=%0d cycles expected<=%0d", cyc, CYC_LIMIT);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 2 * NUM_IN && exp_q.size() > 0; k++) step();
    step();
  endtask

  initial begin
    passed = 0;
    total  = 0;
    cyc    = 0;
    rst_n            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.out_ready    = 1'b1;
    bus.cfg_mode     = 2'b00;
    bus.cfg_sel      = '0;
    bus.cfg_scan_len = '0;
    set_vec(8'h00);

    // Reset
    step();
    step();
    rst_n = 1'b1;
    step();

    // Static, sel=5
    set_vec(8'h10);
    bus.cfg_mode = 2'b00; bus.cfg_sel = 3'd5; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("static_data_k", bus.out_data, 8'h15);
    chk("static_sel_k", bus.out_sel, 5);
    chk("static_last_k", bus.out_last, 1);
    step();
    step();

    // Scan up, scan_len=3
    bus.cfg_mode = 2'b01; bus.cfg_scan_len = 3'd3; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("up_first_k", bus.out_data, 8'h10);
    drain();

    // Scan down, scan_len=7, out_ready 1,0,0,1,...
    bus.cfg_mode = 2'b10; bus.cfg_scan_len = 3'd7; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("dn_first_k", bus.out_data, 8'h17);
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
      bus.out_ready = ((k % 3) == 0);
      step();
    end
    drain();

    // Back-to-back: second vector presented during the first one's last beat
    bus.cfg_mode = 2'b01; bus.cfg_scan_len = 3'd2; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    set_vec(8'h20);
    bus.cfg_mode = 2'b01; bus.cfg_scan_len = 3'd1; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("b2b_valid_k", bus.out_valid, 1);
    chk("b2b_data_k", bus.out_data, 8'h20);
    chk("b2b_sel_k", bus.out_sel, 0);
    drain();

    // Config change mid-scan has no effect on the vector in flight
    set_vec(8'h10);
    bus.cfg_mode = 2'b01; bus.cfg_scan_len = 3'd3; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    bus.cfg_scan_len = 3'd0; bus.cfg_mode = 2'b10;
    drain();

    // Reset during beat 2 of 4
    bus.cfg_mode = 2'b01; bus.cfg_scan_len = 3'd3; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    chk("rst_valid_k", bus.out_valid, 0);
    chk("rst_in_ready_k", bus.in_ready, 0);
    rst_n = 1'b1;
    step();
    step();

    // Boundary: scan_len=0 both directions, reserved mode
    bus.cfg_mode = 2'b01; bus.cfg_scan_len = 3'd0; bus.in_valid = 1'b1;
    step();
    bus.cfg_mode = 2'b10;
    step();
    bus.cfg_mode = 2'b11; bus.cfg_sel = 3'd7;
    step();
    drain();

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < NUM_IN; i++) bus.in_data[i] = WIDTH'($urandom);
      bus.in_valid     = ($urandom_range(0, 2) != 0);
      bus.cfg_mode     = 2'($urandom_range(0, 3));
      bus.cfg_sel      = SEL_WIDTH'($urandom);
      bus.cfg_scan_len = SEL_WIDTH'($urandom);
      bus.out_ready    = ($urandom_range(0, 3) != 0);
      rst_n            = ($urandom_range(0, 63) != 0);
      step();
    end
    rst_n = 1'b1;
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pe_mux_seq.md
Name: pe_mux_seq

Overview:
- Sequenced, handshaked successor of the PE combinational selector.
- Accepts a full vector of NUM_IN operand lanes in one valid/ready transfer and registers it.
- Emits one lane per output transfer, either a single statically chosen lane or a programmable scan (up or down) over lanes 0..scan_len, tagging each beat with its lane index and a last flag.
- Sits between a PE row's result vector and a narrow serial consumer (accumulator / writeback path).

Parameters:
- WIDTH, 8, lane data width in bits.
- SEL_WIDTH, 3, lane index width; NUM_IN = 1<<SEL_WIDTH lanes (derived localparam, not overridable).

Ports:
- clk  input  1  single clock, all logic rising-edge.
- rst_n  input  1  synchronous, active-low reset.
- in_data  input  [WIDTH-1:0] x NUM_IN (unpacked array)  operand vector.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts vector this cycle.
- cfg_mode  input  2  00 static, 01 scan up, 10 scan down, 11 treated as static.
- cfg_sel  input  SEL_WIDTH  lane chosen in static mode.
- cfg_scan_len  input  SEL_WIDTH  last lane index of scan; scan covers scan_len+1 lanes.
- out_data  output  WIDTH  selected lane.
- out_sel  output  SEL_WIDTH  lane index of out_data.
- out_last  output  1  final beat for the current vector.
- out_valid  output  1  output beat valid.
- out_ready  input  1  consumer accepts beat.

Behaviour:
- States: IDLE, EMIT. Reset (rst_n=0 at clk edge) forces IDLE.
  - Clears hold register, counter and latched config to 0.
  - Discards any vector in flight; no partial beats after reset.
- in_ready = rst_n && (state==IDLE || (out_valid && out_ready && out_last)). Back-to-back vectors are accepted with zero bubble.
- Load (in_valid && in_ready):
  - Latch in_data into hold[], and latch cfg_mode, cfg_sel, cfg_scan_len.
  - Counter init: static → cfg_sel; scan up → 0; scan down → cfg_scan_len.
  - Next state EMIT.
  - cfg_* changes while in EMIT have no effect until the next load.
- EMIT:
  - out_valid=1, out_data=hold[cnt], out_sel=cnt.
  - out_last: static → 1; scan up → (cnt==scan_len); scan down → (cnt==0).
  - Outputs depend only on registers; no combinational in→out data path.
- Beat accepted (out_valid && out_ready):
  - Not last: scan up cnt+1, scan down cnt-1.
  - Last: if a simultaneous load occurs, reinitialise per Load and stay in EMIT; otherwise go to IDLE.
- Backpressure: out_ready=0 holds out_data, out_sel, out_last and cnt stable; out_valid never drops without a handshake.
- Boundary cases:
  - scan_len=0 → single beat, lane 0, last=1.
  - scan_len=NUM_IN-1 → full sweep, no wrap past NUM_IN-1 and no underflow below 0.
- While out_valid=0, out_data, out_sel and out_last read 0.
- Latency: vector accepted at edge N → first beat valid from N+1. Throughput is 1 beat/cycle with out_ready held high.

Decomposition:
- pe_pkg: enum pe_sel_mode_e {PE_SEL_STATIC, PE_SEL_SCAN_UP, PE_SEL_SCAN_DN, PE_SEL_RSVD}; state enum pe_mux_seq_state_e {IDLE, EMIT}.
- Sub-module: instantiate the existing pe_mux (WIDTH, SEL_WIDTH) for hold[cnt] selection. Control FSM and counter stay in pe_mux_seq.

Test Plan:
- Static: hold lanes = 8'h10..8'h17, mode 00, sel=5, out_ready=1 → one beat 8'h15, out_sel=5, last=1; in_ready=1 the cycle after.
- Scan up: scan_len=3, out_ready=1 → beats 8'h10,11,12,13 on consecutive cycles, out_sel 0..3, last only on 3; in_ready high only in the last-beat cycle.
- Scan down with backpressure: scan_len=7, out_ready toggling 1,0,0,1,… → order 8'h17 down to 8'h10; outputs frozen while out_ready=0; exactly 8 beats.
- Back-to-back: second vector (8'h20..27, mode 01, scan_len=1) presented during first vector's last beat → accepted that cycle; next cycle 8'h20, no bubble.
- Config change mid-scan: cfg_scan_len changed 3→0 after first beat → still 4 beats from the original vector.
- Reset mid-scan: rst_n=0 during beat 2 of 4 → next cycle out_valid=0, in_ready=0; after release in_ready=1, no stale beats.
